// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg -- shared definitions for the bit-FIFO to UART transmitter.
//   DATA_W          : bits gathered per UART frame
//   CLK_DIV_DEFAULT : default clk cycles per UART bit (12 MHz / 115200)
//   state_e         : FSM state encoding (value 3'd7 is unused)
package fifo_uart_pkg;

  localparam int DATA_W          = 8;
  localparam int CLK_DIV_DEFAULT = 104;
  localparam int CNT_W           = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if -- upstream bit-FIFO handshake plus UART line.
//   I_DATA     : serial bit presented by the FIFO
//   fifo_empty : FIFO holds no bits
//   fifo_busy  : FIFO operation in progress, I_DATA not valid
//   pop        : one-cycle request for the next bit
//   O_TX       : UART line, idle high
//   busy       : gathering or transmitting
// master = FIFO / environment side, slave = transmitter side.
interface fifo_uart_tx_if;
  logic I_DATA;
  logic fifo_empty;
  logic fifo_busy;
  logic pop;
  logic O_TX;
  logic busy;

  modport master (output I_DATA, fifo_empty, fifo_busy, input pop, O_TX, busy);
  modport slave  (input I_DATA, fifo_empty, fifo_busy, output pop, O_TX, busy);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// baud_gen -- bit-period counter for the UART transmitter.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   restart : hold the counter at 0 (asserted while no frame is on the line)
//   tick    : high on the last cycle of each CLK_DIV-cycle bit period
module baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q;

  assign tick = !restart && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- gathers 8 bits one at a time from an upstream bit FIFO
// (LSB first) and sends them as one UART frame.
//   clk   : system clock
//   reset : asynchronous active-low reset; forces the line high at once
//   bus   : fifo_uart_tx_if.slave (I_DATA, fifo_empty, fifo_busy -> pop, O_TX, busy)
// Configuration: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit
// (11-bit frame); undefined gives a plain 8N1 10-bit frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_uart_tx_if.slave        bus
);

  state_e              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                pop_q;
  logic                tx_q;
  logic                rst_done_q;   // holds off the first pop by one edge after reset
  logic                tick;
  logic                in_frame;
  logic [2:0]          next_idx;

  assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign next_idx = bit_cnt_q[2:0] + 3'd1;

  // Counter is held at 0 outside a frame so START always begins a full period.
  baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(!in_frame),
    .tick   (tick)
  );

  assign bus.pop  = pop_q;
  assign bus.O_TX = tx_q;
  assign bus.busy = (state_q != ST_IDLE) || (bit_cnt_q != '0);

  // NOTE: every register here uses non-blocking assignment, so all branches
  // see the pre-edge values of state_q/bit_cnt_q regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      // NOTE: the gather register is reset too, so bits from an aborted
      // frame can never reappear in the next one.
      shift_q    <= '0;
      pop_q      <= 1'b0;
      tx_q       <= 1'b1;
      rst_done_q <= 1'b0;
    end else begin
      pop_q      <= 1'b0;
      rst_done_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (rst_done_q && !bus.fifo_empty && !bus.fifo_busy) begin
            state_q <= ST_POP;
            pop_q   <= 1'b1;
          end
        end
        ST_POP: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (!bus.fifo_busy) begin
            shift_q[bit_cnt_q[2:0]] <= bus.I_DATA;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= ST_START;
              tx_q      <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
              tx_q      <= ^shift_q;
`else
              state_q   <= ST_STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[next_idx];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          tx_q      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx -- scoreboard bench for fifo_uart_tx with CLK_DIV=4.
// A FIFO model feeds bits on pop; a UART monitor decodes frames from O_TX
// and compares them against bytes queued by the stimulus.
module tb_fifo_uart_tx;

  localparam int DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk;
  logic rst_n;

  fifo_uart_tx_if bus ();

  fifo_uart_tx #(.CLK_DIV(DIV)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic       fifo_q[$];
  logic [7:0] sb[$];
  int         busy_len  = 2;
  int         busy_cnt  = 0;
  int         pop_count = 0;
  logic       cur_bit   = 1'b0;
  logic       in_frame  = 1'b0;
  int         frames    = 0;

  // While fifo_busy is high I_DATA carries the inverted bit, so a premature
  // capture shows up as a data error.
  initial begin
    bus.I_DATA     = 1'b0;
    bus.fifo_busy  = 1'b0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        busy_cnt      = 0;
        bus.fifo_busy = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            bus.fifo_busy = 1'b0;
            bus.I_DATA    = cur_bit;
          end
        end
        if (bus.pop === 1'b1) begin
          check("pop_when_empty", 32'(fifo_q.size() == 0), 32'd0);
          check("pop_in_frame", 32'(in_frame), 32'd0);
          pop_count++;
          if (fifo_q.size() != 0) cur_bit = fifo_q.pop_front();
          bus.I_DATA    = ~cur_bit;
          bus.fifo_busy = 1'b1;
          busy_cnt      = busy_len;
        end
      end
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- UART monitor ----------------
  initial begin
    logic       samples[FRAME_BITS*DIV];
    logic       aborted;
    logic [7:0] data;
    logic [7:0] exp;
    int         bad;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.O_TX === 1'b0) begin
        in_frame   = 1'b1;
        aborted    = 1'b0;
        samples[0] = 1'b0;
        for (int k = 1; k < FRAME_BITS * DIV; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          samples[k] = bus.O_TX;
        end
        in_frame = 1'b0;
        if (!aborted) begin
          bad = 0;
          for (int i = 0; i < FRAME_BITS; i++)
            for (int j = 1; j < DIV; j++)
              if (samples[i*DIV+j] !== samples[i*DIV]) bad++;
          for (int i = 0; i < 8; i++) data[i] = samples[(i+1)*DIV];
          check("bit_timing", 32'(bad), 32'd0);
          check("stop_bit", 32'(samples[(FRAME_BITS-1)*DIV]), 32'd1);
          if (sb.size() == 0) begin
            check("unexpected_frame", 32'(data), 32'hFFFF_FFFF);
          end else begin
            exp = sb.pop_front();
            check("frame_data", 32'(data), 32'(exp));
`ifdef FIFO_UART_TX_PARITY_EN
            check("parity_bit", 32'(samples[9*DIV]), 32'(^exp));
`endif
          end
          frames++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_bits(input logic [7:0] b, input int first, input int last);
    for (int i = first; i <= last; i++) fifo_q.push_back(b[i]);
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && fifo_q.size() == 0 && bus.busy === 1'b0 && !in_frame) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   f0;
    int   bad_busy;
    int   bad_tx;
    logic ok;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.O_TX), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pop", 32'(bus.pop), 32'd0);
    #1 rst_n = 1'b1;

    // Byte 0xA5 from bits 1,0,1,0,0,1,0,1; exactly 8 pops.
    pop_count = 0;
    sb.push_back(8'hA5);
    push_bits(8'hA5, 0, 7);
    wait_idle("wait_a5");
    check("pop_count_a5", 32'(pop_count), 32'd8);

    // FIFO runs dry after 3 bits of 0x3C, refilled 50 cycles later.
    pop_count = 0;
    sb.push_back(8'h3C);
    push_bits(8'h3C, 0, 2);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (pop_count == 3) begin ok = 1'b1; break; end
    end
    check("partial_pops", 32'(ok), 32'd1);
    repeat (6) @(posedge clk);
    bad_busy = 0;
    bad_tx   = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.O_TX !== 1'b1) bad_tx++;
    end
    check("partial_busy", 32'(bad_busy), 32'd0);
    check("partial_tx_idle", 32'(bad_tx), 32'd0);
    check("partial_pop_count", 32'(pop_count), 32'd3);
    push_bits(8'h3C, 3, 7);
    wait_idle("wait_3c");

    // Long fifo_busy: I_DATA is inverted until busy falls.
    busy_len = 10;
    sb.push_back(8'h96);
    push_bits(8'h96, 0, 7);
    wait_idle("wait_96");
    busy_len = 2;

    // 0x07: parity bit 1 when parity is enabled.
    sb.push_back(8'h07);
    push_bits(8'h07, 0, 7);
    wait_idle("wait_07");

    // Reset during DATA bit 2 of 0xF0 (line low there); frame discarded.
    push_bits(8'hF0, 0, 7);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (in_frame) begin ok = 1'b1; break; end
    end
    check("abort_frame_seen", 32'(ok), 32'd1);
    repeat (12) @(posedge clk);
    #2;
    check("tx_before_reset", 32'(bus.O_TX), 32'd0);
    rst_n = 1'b0;
    fifo_q.delete();
    #1;
    check("reset_tx_async", 32'(bus.O_TX), 32'd1);
    check("reset_busy_async", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    sb.push_back(8'h81);
    push_bits(8'h81, 0, 7);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("no_pop_first_edge", 32'(bus.pop), 32'd0);
    wait_idle("wait_81");

    // Back-to-back 16 bits: 0xA5 then 0x3C.
    f0 = frames;
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    push_bits(8'hA5, 0, 7);
    push_bits(8'h3C, 0, 7);
    wait_idle("wait_b2b");
    check("b2b_frames", 32'(frames - f0), 32'd2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
